// File: rtl/dac_pkg.sv
// Shared definitions for the access-controller keypad front end:
// key codes, scanner state encoding and the keypad layout.
package dac_pkg;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   typedef enum logic [1:0] {
      ST_SCAN         = 2'd0,
      ST_DEBOUNCE     = 2'd1,
      ST_EMIT         = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } scan_state_t;

   // Physical keypad layout: row 0 = 1 2 3 A ... row 3 = * 0 # D
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'd0:    code = KEY_1;
         4'd1:    code = KEY_2;
         4'd2:    code = KEY_3;
         4'd3:    code = KEY_A;
         4'd4:    code = KEY_4;
         4'd5:    code = KEY_5;
         4'd6:    code = KEY_6;
         4'd7:    code = KEY_B;
         4'd8:    code = KEY_7;
         4'd9:    code = KEY_8;
         4'd10:   code = KEY_9;
         4'd11:   code = KEY_C;
         4'd12:   code = KEY_STAR;
         4'd13:   code = KEY_0;
         4'd14:   code = KEY_HASH;
         4'd15:   code = KEY_D;
         default: code = KEY_0;
      endcase
      return code;
   endfunction

   // One-cold row drive pattern for a row index
   function automatic logic [3:0] row_drive(input logic [1:0] row);
      return ~(4'b0001 << row);
   endfunction

   // True when exactly one column is active
   function automatic logic single_low(input logic [3:0] low);
      return (low != 4'b0000) && ((low & (low - 4'b0001)) == 4'b0000);
   endfunction

   // Column index of a single active column
   function automatic logic [1:0] col_index(input logic [3:0] low);
      logic [1:0] idx;
      case (low)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/dac_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low column returns.
module dac_sync2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   // two-stage capture; idle (all released) after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 4'b1111;
         q    <= 4'b1111;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dac_keypad_encoder.sv
// 4x4 matrix keypad scanner with debounce, ghost rejection and key encoding.
// Emits one key_valid pulse plus at most one named strobe per accepted press.
module dac_keypad_encoder
   import dac_pkg::*;
#(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       RESET,
   output logic [3:0] row_n,
   input  logic [3:0] col_n,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       ONE,
   output logic       THREE,
   output logic       FIVE,
   output logic       SEVEN,
   output logic       A,
   output logic       use_code,
   output logic       DOOR_RESET
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SLOT_INC  = CW'(1);
   localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE);
   localparam logic [DW-1:0] DB_INC    = DW'(1);

   scan_state_t   state;
   logic [CW-1:0] slot;
   logic [DW-1:0] stable;
   logic [1:0]    row;
   logic [1:0]    key_row;
   logic [1:0]    key_col;

   logic [3:0]    col_s;
   logic [3:0]    col_low;
   logic          sample;
   logic          one_low;
   logic [1:0]    low_idx;
   logic [1:0]    next_row;
   logic [DW-1:0] stable_next;
   logic [3:0]    emit_code;

   dac_sync2 u_sync (
      .clk   (clk),
      .reset (RESET),
      .d     (col_n),
      .q     (col_s)
   );

   assign col_low     = ~col_s;
   assign sample      = (slot == SLOT_LAST);
   assign one_low     = single_low(col_low);
   assign low_idx     = col_index(col_low);
   assign next_row    = row + 2'd1;
   assign stable_next = stable + DB_INC;
   assign emit_code   = key_map(key_row, key_col);

   // scan sequencer: slot timing, row drive, key capture and one-cycle strobes
   always_ff @(posedge clk) begin
      if (RESET) begin
         state      <= ST_SCAN;
         slot       <= {CW{1'b0}};
         stable     <= {DW{1'b0}};
         row        <= 2'd0;
         row_n      <= 4'b1110;
         key_row    <= 2'd0;
         key_col    <= 2'd0;
         key_valid  <= 1'b0;
         key_code   <= 4'h0;
         ONE        <= 1'b0;
         THREE      <= 1'b0;
         FIVE       <= 1'b0;
         SEVEN      <= 1'b0;
         A          <= 1'b0;
         use_code   <= 1'b0;
         DOOR_RESET <= 1'b0;
      end else begin
         slot       <= sample ? {CW{1'b0}} : slot + SLOT_INC;
         key_valid  <= 1'b0;
         key_code   <= 4'h0;
         ONE        <= 1'b0;
         THREE      <= 1'b0;
         FIVE       <= 1'b0;
         SEVEN      <= 1'b0;
         A          <= 1'b0;
         use_code   <= 1'b0;
         DOOR_RESET <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (sample) begin
                  if (col_low == 4'b0000) begin
                     row   <= next_row;
                     row_n <= row_drive(next_row);
                  end else if (one_low) begin
                     key_row <= row;
                     key_col <= low_idx;
                     stable  <= {DW{1'b0}};
                     state   <= ST_DEBOUNCE;
                  end else begin
                     // several columns low: possible ghosting, wait it out silently
                     stable <= {DW{1'b0}};
                     state  <= ST_WAIT_RELEASE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (sample) begin
                  if (one_low && (low_idx == key_col)) begin
                     if (stable_next == DB_TARGET) begin
                        stable     <= {DW{1'b0}};
                        state      <= ST_EMIT;
                        key_valid  <= 1'b1;
                        key_code   <= emit_code;
                        ONE        <= (emit_code == KEY_1);
                        THREE      <= (emit_code == KEY_3);
                        FIVE       <= (emit_code == KEY_5);
                        SEVEN      <= (emit_code == KEY_7);
                        A          <= (emit_code == KEY_A);
                        use_code   <= (emit_code == KEY_STAR);
                        DOOR_RESET <= (emit_code == KEY_HASH);
                     end else begin
                        stable <= stable_next;
                     end
                  end else begin
                     stable <= {DW{1'b0}};
                     state  <= ST_SCAN;
                     row    <= next_row;
                     row_n  <= row_drive(next_row);
                  end
               end
            end
            ST_EMIT: begin
               // strobes were raised on entry and drop back by default this cycle
               stable <= {DW{1'b0}};
               state  <= ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
               if (sample) begin
                  if (col_low == 4'b0000) begin
                     if (stable_next == DB_TARGET) begin
                        stable <= {DW{1'b0}};
                        state  <= ST_SCAN;
                        row    <= next_row;
                        row_n  <= row_drive(next_row);
                     end else begin
                        stable <= stable_next;
                     end
                  end else begin
                     stable <= {DW{1'b0}};
                  end
               end
            end
            default: begin
               stable <= {DW{1'b0}};
               state  <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_keypad_encoder.sv
// Self-checking bench for dac_keypad_encoder: a physical keypad model drives
// col_n from row_n and a set of pressed keys; emissions are logged and checked
// against the keypad table, strobe table and timing windows.
module tb_dac_keypad_encoder;

   localparam int SD      = 4;
   localparam int DB      = 2;
   localparam int LAT_MAX = 40;
   localparam logic [3:0] CODE_TAB [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                            4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC,
                                            4'hE, 4'h0, 4'hF, 4'hD};

   logic       clk = 1'b0;
   logic       RESET;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       key_valid;
   logic [3:0] key_code;
   logic       ONE, THREE, FIVE, SEVEN, A, use_code, DOOR_RESET;
   logic [15:0] pressed;

   int cyc     = 0;
   int n_cmp   = 0;
   int n_bad   = 0;
   int inv_bad = 0;

   logic [3:0] ev_code [$];
   int         ev_cyc  [$];
   logic [6:0] ev_strb [$];

   wire [6:0] strb = {ONE, THREE, FIVE, SEVEN, A, use_code, DOOR_RESET};

   always #5 clk = ~clk;

   dac_keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk        (clk),
      .RESET      (RESET),
      .row_n      (row_n),
      .col_n      (col_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .ONE        (ONE),
      .THREE      (THREE),
      .FIVE       (FIVE),
      .SEVEN      (SEVEN),
      .A          (A),
      .use_code   (use_code),
      .DOOR_RESET (DOOR_RESET)
   );

   // Named strobe expected for a key code, bit order {1,3,5,7,A,*,#}
   function automatic logic [6:0] exp_strb(input logic [3:0] c);
      case (c)
         4'h1:    return 7'b1000000;
         4'h3:    return 7'b0100000;
         4'h5:    return 7'b0010000;
         4'h7:    return 7'b0001000;
         4'hA:    return 7'b0000100;
         4'hE:    return 7'b0000010;
         4'hF:    return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   // Keypad matrix: a pressed key shorts its column to the driven (low) row
   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Emission logger and per-cycle output invariants
   always @(negedge clk) begin
      if (key_valid) begin
         ev_code.push_back(key_code);
         ev_cyc.push_back(cyc);
         ev_strb.push_back(strb);
      end
      if (($countones(strb) > 1) ||
          (!key_valid && (key_code !== 4'h0 || strb !== 7'b0)) ||
          (key_valid && strb !== exp_strb(key_code)) ||
          ($countones(~row_n) != 1))
         inv_bad <= inv_bad + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      ev_code.delete();
      ev_cyc.delete();
      ev_strb.delete();
   endtask

   task automatic wait_row(input logic [3:0] target);
      for (int i = 0; i < 60 && row_n !== target; i++) tick(1);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      pressed = 16'h0;
      tick(3);
      n_cmp++; if (row_n !== 4'b1110) begin n_bad++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
      n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code: got %h want 0", key_code); end
      n_cmp++; if (strb !== 7'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0", strb); end
      RESET = 1'b0;
   endtask

   task automatic test_held_key();
      int t0;
      int frozen_bad = 0;
      clear_log();
      t0 = cyc;
      pressed[5] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (ev_code.size() > 0 && row_n !== 4'b1101) frozen_bad++;
      end
      pressed = 16'h0;
      tick(30);
      n_cmp++; if (ev_code.size() !== 1) begin n_bad++; $display("FAIL held_count: got %0d want 1", ev_code.size()); end
      n_cmp++;
      if (ev_code.size() < 1) begin n_bad++; $display("FAIL held_code: got none want 5"); end
      else if (ev_code[0] !== 4'h5 || ev_strb[0] !== 7'b0010000) begin
         n_bad++; $display("FAIL held_code: got %h/%b want 5/0010000", ev_code[0], ev_strb[0]);
      end
      n_cmp++; if (frozen_bad !== 0) begin n_bad++; $display("FAIL held_row_frozen: got %0d bad cycles want 0", frozen_bad); end
      n_cmp++;
      if (ev_cyc.size() < 1 || ev_cyc[0] - t0 < DB*SD || ev_cyc[0] - t0 > LAT_MAX) begin
         n_bad++; $display("FAIL held_latency: got %0d want %0d..%0d", (ev_cyc.size() > 0) ? ev_cyc[0] - t0 : -1, DB*SD, LAT_MAX);
      end
   endtask

   task automatic test_sequence();
      int keys [5] = '{5, 2, 3, 0, 8};
      clear_log();
      for (int i = 0; i < 5; i++) begin
         pressed[keys[i]] = 1'b1;
         tick(60);
         pressed = 16'h0;
         tick(60);
      end
      n_cmp++; if (ev_code.size() !== 5) begin n_bad++; $display("FAIL seq_count: got %0d want 5", ev_code.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= ev_code.size()) begin n_bad++; $display("FAIL seq_item%0d: got none want %h", i, CODE_TAB[keys[i]]); end
         else if (ev_code[i] !== CODE_TAB[keys[i]] || ev_strb[i] !== exp_strb(CODE_TAB[keys[i]])) begin
            n_bad++; $display("FAIL seq_item%0d: got %h/%b want %h/%b", i, ev_code[i], ev_strb[i],
                              CODE_TAB[keys[i]], exp_strb(CODE_TAB[keys[i]]));
         end
      end
   endtask

   task automatic test_latency();
      int s;
      int want;
      pressed = 16'h0;
      tick(30);
      clear_log();
      wait_row(4'b0111);
      wait_row(4'b1110);
      pressed[5] = 1'b1;
      wait_row(4'b1101);
      n_cmp++; if (row_n !== 4'b1101) begin n_bad++; $display("FAIL lat_row_timeout: got %b want 1101", row_n); end
      s = cyc;
      want = s + (DB + 1) * SD;
      tick(40);
      pressed = 16'h0;
      tick(30);
      n_cmp++;
      if (ev_cyc.size() !== 1 || ev_cyc[0] < want || ev_cyc[0] > want + 2) begin
         n_bad++; $display("FAIL lat_exact: got %0d events first at %0d want one at %0d..%0d",
                           ev_cyc.size(), (ev_cyc.size() > 0) ? ev_cyc[0] : -1, want, want + 2);
      end
   endtask

   task automatic test_bounce();
      int t_end;
      int early = 0;
      pressed = 16'h0;
      tick(30);
      clear_log();
      for (int i = 0; i < 10; i++) begin
         pressed[0] = ~pressed[0];
         tick(3);
      end
      pressed[0] = 1'b1;
      t_end = cyc;
      tick(60);
      pressed = 16'h0;
      tick(30);
      foreach (ev_cyc[i]) if (ev_cyc[i] <= t_end) early++;
      n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL bounce_early: got %0d pulses want 0", early); end
      n_cmp++;
      if (ev_code.size() !== 1 || ev_code[0] !== 4'h1 || ev_strb[0] !== 7'b1000000) begin
         n_bad++; $display("FAIL bounce_one: got %0d events first %h want 1 event code 1",
                           ev_code.size(), (ev_code.size() > 0) ? ev_code[0] : 4'h0);
      end
   endtask

   task automatic test_ghost();
      pressed = 16'h0;
      tick(30);
      clear_log();
      pressed[0] = 1'b1;
      pressed[1] = 1'b1;
      tick(80);
      n_cmp++; if (ev_code.size() !== 0) begin n_bad++; $display("FAIL ghost_reject: got %0d pulses want 0", ev_code.size()); end
      pressed = 16'h0;
      tick(40);
      pressed[14] = 1'b1;
      tick(60);
      pressed = 16'h0;
      tick(30);
      n_cmp++;
      if (ev_code.size() !== 1 || ev_code[0] !== 4'hF || ev_strb[0] !== 7'b0000001) begin
         n_bad++; $display("FAIL ghost_hash: got %0d events first %h want 1 event code F with DOOR_RESET",
                           ev_code.size(), (ev_code.size() > 0) ? ev_code[0] : 4'h0);
      end
   endtask

   task automatic test_reset_mid();
      int rst_cyc;
      pressed = 16'h0;
      tick(30);
      clear_log();
      pressed[12] = 1'b1;
      wait_row(4'b1110);
      wait_row(4'b0111);
      n_cmp++; if (row_n !== 4'b0111) begin n_bad++; $display("FAIL rstmid_row_timeout: got %b want 0111", row_n); end
      tick(SD + 3);
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      rst_cyc = cyc;
      n_cmp++; if (row_n !== 4'b1110) begin n_bad++; $display("FAIL rstmid_row_n: got %b want 1110", row_n); end
      n_cmp++; if (ev_code.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", ev_code.size()); end
      tick(60);
      pressed = 16'h0;
      tick(30);
      n_cmp++;
      if (ev_code.size() !== 1 || ev_code[0] !== 4'hE || ev_strb[0] !== 7'b0000010 || ev_cyc[0] < rst_cyc + 3*SD) begin
         n_bad++; $display("FAIL rstmid_star: got %0d events first %h at %0d want 1 event code E after %0d",
                           ev_code.size(), (ev_code.size() > 0) ? ev_code[0] : 4'h0,
                           (ev_cyc.size() > 0) ? ev_cyc[0] : -1, rst_cyc + 3*SD);
      end
   endtask

   task automatic test_other_row();
      int rel;
      pressed = 16'h0;
      tick(30);
      clear_log();
      pressed[5] = 1'b1;
      tick(40);
      pressed[10] = 1'b1;
      tick(40);
      n_cmp++; if (ev_code.size() !== 1) begin n_bad++; $display("FAIL other_row_ignored: got %0d events want 1", ev_code.size()); end
      pressed[5] = 1'b0;
      rel = cyc;
      tick(60);
      pressed = 16'h0;
      tick(30);
      n_cmp++;
      if (ev_code.size() !== 2 || ev_code[1] !== 4'h9 || ev_strb[1] !== 7'b0 || ev_cyc[1] <= rel) begin
         n_bad++; $display("FAIL other_row_after: got %0d events second %h want 2 events second 9 after release",
                           ev_code.size(), (ev_code.size() > 1) ? ev_code[1] : 4'h0);
      end
   endtask

   task automatic test_random();
      int kq [$];
      int pt [$];
      int k;
      pressed = 16'h0;
      tick(30);
      clear_log();
      for (int i = 0; i < 12; i++) begin
         k = $urandom_range(0, 15);
         kq.push_back(k);
         pt.push_back(cyc);
         pressed[k] = 1'b1;
         tick($urandom_range(50, 90));
         pressed = 16'h0;
         tick($urandom_range(30, 50));
      end
      n_cmp++; if (ev_code.size() !== 12) begin n_bad++; $display("FAIL rand_count: got %0d want 12", ev_code.size()); end
      for (int i = 0; i < 12; i++) begin
         n_cmp++;
         if (i >= ev_code.size()) begin n_bad++; $display("FAIL rand_item%0d: got none want %h", i, CODE_TAB[kq[i]]); end
         else if (ev_code[i] !== CODE_TAB[kq[i]] || ev_strb[i] !== exp_strb(CODE_TAB[kq[i]]) ||
                  ev_cyc[i] - pt[i] < DB*SD || ev_cyc[i] - pt[i] > LAT_MAX) begin
            n_bad++; $display("FAIL rand_item%0d: got %h/%b lat %0d want %h/%b lat %0d..%0d", i, ev_code[i], ev_strb[i],
                              ev_cyc[i] - pt[i], CODE_TAB[kq[i]], exp_strb(CODE_TAB[kq[i]]), DB*SD, LAT_MAX);
         end
      end
   endtask

   task automatic test_idle_scan();
      logic [3:0] prev;
      int len = 0;
      int changes = 0;
      int bad = 0;
      logic started = 1'b0;
      pressed = 16'h0;
      tick(30);
      clear_log();
      prev = row_n;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (row_n !== prev) begin
            if (row_n !== {prev[2:0], prev[3]}) bad++;
            if (started && len != SD) bad++;
            started = 1'b1;
            len = 1;
            changes++;
            prev = row_n;
         end else begin
            len++;
         end
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_rotation: got %0d bad steps want 0", bad); end
      n_cmp++; if (changes < 20) begin n_bad++; $display("FAIL idle_changes: got %0d want >=20", changes); end
      n_cmp++; if (ev_code.size() !== 0) begin n_bad++; $display("FAIL idle_no_pulse: got %0d want 0", ev_code.size()); end
   endtask

   task automatic test_invariants();
      n_cmp++; if (inv_bad !== 0) begin n_bad++; $display("FAIL invariants: got %0d bad cycles want 0", inv_bad); end
   endtask

   initial begin
      RESET = 1'b1;
      pressed = 16'h0;
      test_reset();
      test_held_key();
      test_sequence();
      test_latency();
      test_bounce();
      test_ghost();
      test_reset_mid();
      test_other_row();
      test_random();
      test_idle_scan();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
